// File: rtl/ea_astat_stk_pkg.sv
// Shared definitions for the ASTAT / status stack block: ASTAT bit positions
// and the 4-bit condition-code encodings used by conditional instructions.
package ea_astat_stk_pkg;

   // ASTAT bit positions
   localparam int AZ = 0;
   localparam int AN = 1;
   localparam int AV = 2;
   localparam int AC = 3;
   localparam int AS = 4;
   localparam int AQ = 5;
   localparam int MV = 6;
   localparam int SS = 7;

   // Condition codes carried by conditional instructions
   typedef enum logic [3:0] {
      COND_EQ     = 4'd0,
      COND_NE     = 4'd1,
      COND_GT     = 4'd2,
      COND_LE     = 4'd3,
      COND_LT     = 4'd4,
      COND_GE     = 4'd5,
      COND_AV     = 4'd6,
      COND_NOT_AV = 4'd7,
      COND_AC     = 4'd8,
      COND_NOT_AC = 4'd9,
      COND_NEG    = 4'd10,
      COND_POS    = 4'd11,
      COND_MV     = 4'd12,
      COND_NOT_MV = 4'd13,
      COND_NOT_CE = 4'd14,
      COND_TRUE   = 4'd15
   } cond_e;

endpackage

// File: rtl/ea_astat_stk_if.sv
// Execute-stage status bus: flag sources and stack controls into the ASTAT
// block, architectural status and condition result back out.
interface ea_astat_stk_if;
   logic        GO_E;
   logic        updateALU;
   logic        updateDIV;
   logic        ABS;
   logic        AZin, ANin, AVin, ACin, ASin, AQin;
   logic        updateMV, MVin;
   logic        updateSS, SSin;
   logic        MTASTAT_E;
   logic [15:0] R_in_E;
   logic        PUSH_STS, POP_STS;
   logic        CLR_SOV;
   logic [3:0]  COND;
   logic        CE;
   logic [7:0]  ASTAT;
   logic        STKempty, STKfull;
   logic        SOV;
   logic        CONDok;

   modport master (
      output GO_E, updateALU, updateDIV, ABS,
             AZin, ANin, AVin, ACin, ASin, AQin,
             updateMV, MVin, updateSS, SSin,
             MTASTAT_E, R_in_E, PUSH_STS, POP_STS, CLR_SOV, COND, CE,
      input  ASTAT, STKempty, STKfull, SOV, CONDok
   );

   modport slave (
      input  GO_E, updateALU, updateDIV, ABS,
             AZin, ANin, AVin, ACin, ASin, AQin,
             updateMV, MVin, updateSS, SSin,
             MTASTAT_E, R_in_E, PUSH_STS, POP_STS, CLR_SOV, COND, CE,
      output ASTAT, STKempty, STKfull, SOV, CONDok
   );
endinterface

// File: rtl/ea_sts_stack.sv
// Hardware status stack: LIFO of saved ASTAT bytes with its pointer,
// full/empty status and the sticky overflow/underflow/collision flag.
// PTRW must be wide enough that 2**PTRW > DEPTH so the full count fits.
module ea_sts_stack #(
   parameter int DEPTH = 7,
   parameter int PTRW  = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       go,
   input  logic       push,
   input  logic       pop,
   input  logic       clr_err,
   input  logic [7:0] wr_data,
   output logic [7:0] rd_data,
   output logic       pop_ok,
   output logic       empty,
   output logic       full,
   output logic       sov
);

   logic [7:0]      mem [DEPTH];
   logic [PTRW-1:0] ptr;
   logic [PTRW-1:0] ptr_m1;
   logic            push_ok;
   logic            err;

   assign empty   = (ptr == '0);
   assign full    = (ptr == PTRW'(DEPTH));
   assign ptr_m1  = ptr - PTRW'(1);
   assign push_ok = push & ~pop & ~full;
   assign pop_ok  = pop & ~push & ~empty;
   assign err     = (push & pop) | (push & full) | (pop & empty);

   // Stack pointer moves only on a legal push or pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (go) begin
         if (push_ok) begin
            ptr <= ptr + PTRW'(1);
         end else if (pop_ok) begin
            ptr <= ptr_m1;
         end
      end
   end

   // Sticky error flag; a new error outranks a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sov <= 1'b0;
      end else if (go) begin
         if (err) begin
            sov <= 1'b1;
         end else if (clr_err) begin
            sov <= 1'b0;
         end
      end
   end

   // Entry storage carries no reset; only the pointer defines valid entries
   always_ff @(posedge clk) begin
      if (go && push_ok) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (PTRW'(i) == ptr) begin
               mem[i] <= wr_data;
            end
         end
      end
   end

   // Top-of-stack read mux, zero when the stack is empty
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!empty && (PTRW'(i) == ptr_m1)) begin
            rd_data = mem[i];
         end
      end
   end

endmodule

// File: rtl/ea_astat_stk.sv
// Arithmetic status register (ASTAT) with its save/restore stack and the
// condition-code evaluator feeding conditional instructions.
module ea_astat_stk
   import ea_astat_stk_pkg::*;
#(
   parameter int DEPTH = 7,
   parameter int PTRW  = 3
) (
   input  logic           DSPCLK,
   input  logic           T_RST,
   ea_astat_stk_if.slave  bus
);

   logic [7:0] astat;
   logic [7:0] astat_nxt;
   logic [7:0] stk_top;
   logic       pop_ok;
   logic       unused_r_hi;

   assign unused_r_hi = ^bus.R_in_E[15:8];

   ea_sts_stack #(
      .DEPTH (DEPTH),
      .PTRW  (PTRW)
   ) u_stack (
      .clk     (DSPCLK),
      .rst_n   (T_RST),
      .go      (bus.GO_E),
      .push    (bus.PUSH_STS),
      .pop     (bus.POP_STS),
      .clr_err (bus.CLR_SOV),
      .wr_data (astat),
      .rd_data (stk_top),
      .pop_ok  (pop_ok),
      .empty   (bus.STKempty),
      .full    (bus.STKfull),
      .sov     (bus.SOV)
   );

   // Next ASTAT: legal pop, then register write, then merged per-field flags
   always_comb begin
      astat_nxt = astat;
      if (pop_ok) begin
         astat_nxt = stk_top;
      end else if (bus.MTASTAT_E) begin
         astat_nxt = bus.R_in_E[7:0];
      end else begin
         if (bus.updateALU) begin
            astat_nxt[AZ] = bus.AZin;
            astat_nxt[AN] = bus.ANin;
            astat_nxt[AV] = bus.AVin;
            astat_nxt[AC] = bus.ACin;
            if (bus.ABS) begin
               astat_nxt[AS] = bus.ASin;
            end
         end
         if (bus.updateDIV) begin
            astat_nxt[AQ] = bus.AQin;
         end
         if (bus.updateMV) begin
            astat_nxt[MV] = bus.MVin;
         end
         if (bus.updateSS) begin
            astat_nxt[SS] = bus.SSin;
         end
      end
   end

   // Architectural ASTAT register, advancing with the execute stage
   always_ff @(posedge DSPCLK or negedge T_RST) begin
      if (!T_RST) begin
         astat <= 8'h00;
      end else if (bus.GO_E) begin
         astat <= astat_nxt;
      end
   end

   assign bus.ASTAT = astat;

   // Condition decoder working on the registered ASTAT and counter-expired
   always_comb begin
      bus.CONDok = 1'b0;
      case (cond_e'(bus.COND))
         COND_EQ:     bus.CONDok = astat[AZ];
         COND_NE:     bus.CONDok = ~astat[AZ];
         COND_GT:     bus.CONDok = ~((astat[AN] ^ astat[AV]) | astat[AZ]);
         COND_LE:     bus.CONDok = (astat[AN] ^ astat[AV]) | astat[AZ];
         COND_LT:     bus.CONDok = astat[AN] ^ astat[AV];
         COND_GE:     bus.CONDok = ~(astat[AN] ^ astat[AV]);
         COND_AV:     bus.CONDok = astat[AV];
         COND_NOT_AV: bus.CONDok = ~astat[AV];
         COND_AC:     bus.CONDok = astat[AC];
         COND_NOT_AC: bus.CONDok = ~astat[AC];
         COND_NEG:    bus.CONDok = astat[AS];
         COND_POS:    bus.CONDok = ~astat[AS];
         COND_MV:     bus.CONDok = astat[MV];
         COND_NOT_MV: bus.CONDok = ~astat[MV];
         COND_NOT_CE: bus.CONDok = ~bus.CE;
         COND_TRUE:   bus.CONDok = 1'b1;
         default:     bus.CONDok = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_ea_astat_stk.sv
// Directed bench for ea_astat_stk: reset, flag merge, priority, status
// stack LIFO/overflow/underflow behaviour and condition evaluation.
module tb_ea_astat_stk;

   logic DSPCLK = 1'b0;
   logic T_RST  = 1'b0;
   int   nCompared   = 0;
   int   nMismatched = 0;

   ea_astat_stk_if bus();

   ea_astat_stk #(
      .DEPTH (7),
      .PTRW  (3)
   ) dut (
      .DSPCLK (DSPCLK),
      .T_RST  (T_RST),
      .bus    (bus)
   );

   always #5 DSPCLK = ~DSPCLK;

   task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic clearInputs();
      bus.GO_E      = 1'b1;
      bus.updateALU = 1'b0;
      bus.updateDIV = 1'b0;
      bus.ABS       = 1'b0;
      bus.AZin      = 1'b0;
      bus.ANin      = 1'b0;
      bus.AVin      = 1'b0;
      bus.ACin      = 1'b0;
      bus.ASin      = 1'b0;
      bus.AQin      = 1'b0;
      bus.updateMV  = 1'b0;
      bus.MVin      = 1'b0;
      bus.updateSS  = 1'b0;
      bus.SSin      = 1'b0;
      bus.MTASTAT_E = 1'b0;
      bus.R_in_E    = 16'h0000;
      bus.PUSH_STS  = 1'b0;
      bus.POP_STS   = 1'b0;
      bus.CLR_SOV   = 1'b0;
      bus.COND      = 4'd0;
      bus.CE        = 1'b0;
   endtask

   task automatic applyStimulus();
      @(posedge DSPCLK);
      #1;
      clearInputs();
   endtask

   task automatic writeAstat(input logic [7:0] v);
      bus.MTASTAT_E = 1'b1;
      bus.R_in_E    = {8'h00, v};
      applyStimulus();
   endtask

   task automatic pushSts();
      bus.PUSH_STS = 1'b1;
      applyStimulus();
   endtask

   task automatic popSts();
      bus.POP_STS = 1'b1;
      applyStimulus();
   endtask

   task automatic checkCond(input string tag, input logic [3:0] c, input logic ce, input logic exp);
      bus.COND = c;
      bus.CE   = ce;
      #1;
      checkOutput(tag, {7'd0, bus.CONDok}, {7'd0, exp});
   endtask

   initial begin
      clearInputs();
      bus.GO_E = 1'b0;
      T_RST    = 1'b0;
      repeat (2) @(posedge DSPCLK);
      #1;
      checkOutput("rst_astat_held", bus.ASTAT, 8'h00);
      T_RST = 1'b1;
      #1;
      checkOutput("rst_astat", bus.ASTAT, 8'h00);
      checkOutput("rst_empty", {7'd0, bus.STKempty}, 8'h01);
      checkOutput("rst_full", {7'd0, bus.STKfull}, 8'h00);
      checkOutput("rst_sov", {7'd0, bus.SOV}, 8'h00);
      checkCond("rst_cond_true", 4'd15, 1'b0, 1'b1);
      checkCond("rst_cond_eq", 4'd0, 1'b0, 1'b0);
      clearInputs();

      // Flag merge: AS held without ABS
      bus.updateALU = 1'b1;
      bus.AZin = 1'b1; bus.ANin = 1'b1; bus.AVin = 1'b0; bus.ACin = 1'b1; bus.ASin = 1'b1;
      bus.updateDIV = 1'b1; bus.AQin = 1'b1;
      applyStimulus();
      checkOutput("merge_no_abs", bus.ASTAT, 8'h2B);

      bus.updateALU = 1'b1; bus.ABS = 1'b1;
      bus.AZin = 1'b1; bus.ANin = 1'b1; bus.AVin = 1'b0; bus.ACin = 1'b1; bus.ASin = 1'b1;
      bus.updateDIV = 1'b1; bus.AQin = 1'b1;
      applyStimulus();
      checkOutput("merge_abs", bus.ASTAT, 8'h3B);

      bus.updateMV = 1'b1; bus.MVin = 1'b1;
      bus.updateSS = 1'b1; bus.SSin = 1'b1;
      applyStimulus();
      checkOutput("merge_mv_ss", bus.ASTAT, 8'hFB);

      bus.updateMV = 1'b1; bus.MVin = 1'b0;
      applyStimulus();
      checkOutput("merge_mv_clr", bus.ASTAT, 8'hBB);

      // Priority: register write beats flag updates
      bus.MTASTAT_E = 1'b1; bus.R_in_E = 16'h00C0;
      bus.updateALU = 1'b1; bus.AZin = 1'b1;
      applyStimulus();
      checkOutput("prio_mtastat", bus.ASTAT, 8'hC0);

      bus.GO_E = 1'b0;
      bus.MTASTAT_E = 1'b1; bus.R_in_E = 16'h00FF;
      bus.updateALU = 1'b1; bus.AZin = 1'b1; bus.ANin = 1'b1; bus.updateSS = 1'b1;
      bus.PUSH_STS = 1'b1;
      applyStimulus();
      checkOutput("stall_astat", bus.ASTAT, 8'hC0);
      checkOutput("stall_empty", {7'd0, bus.STKempty}, 8'h01);

      // Basic stack round trip
      writeAstat(8'h11);
      pushSts();
      checkOutput("push1_astat", bus.ASTAT, 8'h11);
      checkOutput("push1_empty", {7'd0, bus.STKempty}, 8'h00);
      writeAstat(8'h22);
      pushSts();
      writeAstat(8'h33);
      popSts();
      checkOutput("pop1", bus.ASTAT, 8'h22);
      popSts();
      checkOutput("pop2", bus.ASTAT, 8'h11);
      checkOutput("pop2_empty", {7'd0, bus.STKempty}, 8'h01);
      popSts();
      checkOutput("underflow_sov", {7'd0, bus.SOV}, 8'h01);
      checkOutput("underflow_astat", bus.ASTAT, 8'h11);

      // Empty pop falls through to register write; error beats clear
      bus.POP_STS = 1'b1; bus.MTASTAT_E = 1'b1; bus.R_in_E = 16'h0044; bus.CLR_SOV = 1'b1;
      applyStimulus();
      checkOutput("underflow_mtastat", bus.ASTAT, 8'h44);
      checkOutput("set_beats_clr", {7'd0, bus.SOV}, 8'h01);
      bus.CLR_SOV = 1'b1;
      applyStimulus();
      checkOutput("clr_sov", {7'd0, bus.SOV}, 8'h00);

      // Push saves pre-update ASTAT while the update still lands
      bus.PUSH_STS = 1'b1; bus.MTASTAT_E = 1'b1; bus.R_in_E = 16'h0055;
      applyStimulus();
      checkOutput("push_upd_astat", bus.ASTAT, 8'h55);
      popSts();
      checkOutput("push_upd_saved", bus.ASTAT, 8'h44);
      checkOutput("push_upd_empty", {7'd0, bus.STKempty}, 8'h01);

      // Push and pop together are both dropped
      bus.PUSH_STS = 1'b1; bus.POP_STS = 1'b1;
      applyStimulus();
      checkOutput("collide_sov", {7'd0, bus.SOV}, 8'h01);
      checkOutput("collide_empty", {7'd0, bus.STKempty}, 8'h01);
      checkOutput("collide_astat", bus.ASTAT, 8'h44);
      bus.CLR_SOV = 1'b1;
      applyStimulus();

      // Fill to full, overflow, then drain in LIFO order
      for (int i = 0; i < 7; i++) begin
         writeAstat(8'(8'h60 + i));
         pushSts();
      end
      checkOutput("fill_full", {7'd0, bus.STKfull}, 8'h01);
      checkOutput("fill_sov", {7'd0, bus.SOV}, 8'h00);
      pushSts();
      checkOutput("overflow_sov", {7'd0, bus.SOV}, 8'h01);
      checkOutput("overflow_full", {7'd0, bus.STKfull}, 8'h01);
      bus.CLR_SOV = 1'b1;
      applyStimulus();
      for (int i = 6; i >= 0; i--) begin
         popSts();
         checkOutput($sformatf("lifo_pop%0d", i), bus.ASTAT, 8'(8'h60 + i));
      end
      checkOutput("drain_empty", {7'd0, bus.STKempty}, 8'h01);
      checkOutput("drain_full", {7'd0, bus.STKfull}, 8'h00);
      checkOutput("drain_sov", {7'd0, bus.SOV}, 8'h00);

      // Condition evaluation
      writeAstat(8'h02);
      checkCond("lt_an", 4'd4, 1'b0, 1'b1);
      checkCond("ge_an", 4'd5, 1'b0, 1'b0);
      checkCond("gt_an", 4'd2, 1'b0, 1'b0);
      checkCond("le_an", 4'd3, 1'b0, 1'b1);
      clearInputs();
      writeAstat(8'h06);
      checkCond("ge_an_av", 4'd5, 1'b0, 1'b1);
      checkCond("lt_an_av", 4'd4, 1'b0, 1'b0);
      checkCond("gt_an_av", 4'd2, 1'b0, 1'b1);
      checkCond("av_set", 4'd6, 1'b0, 1'b1);
      clearInputs();
      writeAstat(8'h01);
      checkCond("eq_az", 4'd0, 1'b0, 1'b1);
      checkCond("ne_az", 4'd1, 1'b0, 1'b0);
      checkCond("le_az", 4'd3, 1'b0, 1'b1);
      clearInputs();
      writeAstat(8'h58);
      checkCond("ac", 4'd8, 1'b0, 1'b1);
      checkCond("not_ac", 4'd9, 1'b0, 1'b0);
      checkCond("neg", 4'd10, 1'b0, 1'b1);
      checkCond("pos", 4'd11, 1'b0, 1'b0);
      checkCond("mv", 4'd12, 1'b0, 1'b1);
      checkCond("not_mv", 4'd13, 1'b0, 1'b0);
      checkCond("not_av", 4'd7, 1'b0, 1'b1);
      checkCond("not_ce_1", 4'd14, 1'b1, 1'b0);
      checkCond("not_ce_0", 4'd14, 1'b0, 1'b1);
      clearInputs();

      // Asynchronous reset in the middle of stack activity
      writeAstat(8'h77);
      pushSts();
      bus.PUSH_STS = 1'b1;
      #2;
      T_RST = 1'b0;
      #1;
      checkOutput("async_rst_astat", bus.ASTAT, 8'h00);
      checkOutput("async_rst_empty", {7'd0, bus.STKempty}, 8'h01);
      checkOutput("async_rst_sov", {7'd0, bus.SOV}, 8'h00);
      clearInputs();
      @(posedge DSPCLK);
      #1;
      T_RST = 1'b1;
      popSts();
      checkOutput("post_rst_pop_sov", {7'd0, bus.SOV}, 8'h01);
      checkOutput("post_rst_pop_astat", bus.ASTAT, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/ea_astat_stk.md
Name: ea_astat_stk

Overview:
- Arithmetic status register (ASTAT) plus hardware status stack, directly downstream of the ALU execute stage.
- Captures the per-field flags the ALU, MAC and shifter produce each execute cycle and holds the architectural ASTAT that feeds back into the ALU and sequencer.
- Saves/restores ASTAT on PUSH STS / POP STS.
- Evaluates the 4-bit condition code for conditional instructions.

Parameters:
DEPTH, 7, status stack entries
PTRW, 3, stack pointer width; must satisfy 2**PTRW > DEPTH

Ports:
DSPCLK  in  1  DSP clock
T_RST  in  1  reset, asynchronous, active-low
GO_E  in  1  execute-stage advance; all state updates qualified by GO_E=1
updateALU  in  1  ALU result flags valid this cycle
updateDIV  in  1  divide step flags valid this cycle
ABS  in  1  ABS instruction in execute (qualifies AS)
AZin, ANin, AVin, ACin, ASin, AQin  in  1 each  ALU flag inputs
updateMV, MVin  in  1 each  MAC overflow update/value
updateSS, SSin  in  1 each  shifter sign update/value
MTASTAT_E  in  1  register write to ASTAT
R_in_E  in  16  write data; bits [7:0] used
PUSH_STS, POP_STS  in  1 each  status stack push/pop
CLR_SOV  in  1  clears sticky stack-error flag
COND  in  4  condition code of instruction in execute
CE  in  1  counter-expired from sequencer
ASTAT  out  8  {SS,MV,AQ,AS,AC,AV,AN,AZ} (bit0=AZ, bit3=AC, bit5=AQ)
STKempty, STKfull  out  1 each  stack status
SOV  out  1  sticky stack overflow/underflow/collision
CONDok  out  1  condition true (combinational from ASTAT, CE)

Behaviour:
- Reset (T_RST=0, async):
  - ASTAT=8'h00, SOV=0, pointer=0.
  - STKempty=1, STKfull=0.
  - Stack contents are don't-care.
- GO_E=0: no state changes; outputs hold.
- ASTAT next-value priority per cycle with GO_E=1, highest first:
  1. POP_STS (legal): ASTAT <= stack top.
  2. MTASTAT_E: ASTAT <= R_in_E[7:0].
  3. Per-field flag updates, merged:
     - updateALU writes AZ, AN, AV, AC.
     - updateALU writes AS only when ABS=1; otherwise AS holds.
     - updateDIV writes AQ.
     - updateMV writes MV.
     - updateSS writes SS.
     - Fields not written hold.
- A higher priority source overrides lower ones for the whole byte.
- Latency: flags presented in cycle N are visible on ASTAT after the DSPCLK edge ending cycle N (1 cycle). No internal bypass.
- Push:
  - Stores the current (pre-update) ASTAT at entry[ptr]; ptr+1.
  - Same-cycle flag/MTASTAT updates still apply to ASTAT.
- Pop: ASTAT <= entry[ptr-1]; ptr-1.
- Full push (ptr==DEPTH): push dropped, ptr unchanged, SOV <= 1.
- Empty pop (ptr==0): ASTAT follows the normal priority chain (pop ignored), SOV <= 1.
- PUSH_STS and POP_STS together: both ignored, SOV <= 1.
- STKempty = (ptr==0); STKfull = (ptr==DEPTH). Both are registered-derived, with no glitch paths.
- SOV clear: CLR_SOV clears SOV; a simultaneous error set wins over clear.
- CONDok by COND (from current registered ASTAT):
  - 0 EQ: AZ
  - 1 NE: ~AZ
  - 2 GT: ~((AN^AV)|AZ)
  - 3 LE: (AN^AV)|AZ
  - 4 LT: AN^AV
  - 5 GE: ~(AN^AV)
  - 6 AV
  - 7 ~AV
  - 8 AC
  - 9 ~AC
  - 10 NEG: AS
  - 11 POS: ~AS
  - 12 MV
  - 13 ~MV
  - 14 NOT CE: ~CE
  - 15 TRUE: 1
- Reset asserted mid-push/pop: pointer and ASTAT clear immediately; no partial write is observable.

Decomposition:
- Shared package/include holds:
  - ASTAT bit-index constants: AZ=0, AN=1, AV=2, AC=3, AS=4, AQ=5, MV=6, SS=7.
  - Condition-code encodings 0..15.
- Sub-module ea_sts_stack: LIFO storage, pointer, full/empty and error detection.
- Top contains the ASTAT merge logic and the condition decoder.

Test Plan:
- Reset: release T_RST -> ASTAT=00, STKempty=1, SOV=0; COND=15 -> CONDok=1, COND=0 -> CONDok=0.
- Flag merge:
  - updateALU with AZ,AN,AV,AC,AS=1,1,0,1,1 and ABS=0, plus updateDIV with AQin=1 -> ASTAT=8'h2B.
  - Same inputs with ABS=1 -> ASTAT=8'h3B.
- Priority: MTASTAT_E with R_in_E=16'h00C0 plus updateALU AZin=1 in the same cycle -> ASTAT=C0. GO_E=0 with any updates -> ASTAT unchanged.
- Stack:
  - Write ASTAT=11, push; write 22, push; write 33; pop -> ASTAT=22; pop -> 11, STKempty=1.
  - Third pop -> SOV=1, ASTAT=11.
  - CLR_SOV -> SOV=0.
- Overflow: 7 pushes -> STKfull=1; 8th push -> SOV=1, pointer stays 7; 7 pops return values in LIFO order.
- Conditions: ASTAT with AN=1, AV=0 -> LT=1, GE=0, GT=0; AN=1, AV=1 -> GE=1; CE=1, COND=14 -> CONDok=0.
